// File: rtl/rs_age_cdb_pkg.sv
// Shared widths and constants for the age-ordered reservation station.
package rs_age_cdb_pkg;
  localparam int RS_OP_W  = 6;
  localparam int RS_XLEN  = 32;
  localparam int RS_TAG_W = 4;

  localparam logic [RS_TAG_W-1:0] ZERO_TAG = '0;
  localparam logic [RS_OP_W-1:0]  NOP      = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/rs_age_cdb_select.sv
// Combinational oldest-ready picker driven by the age matrix.
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            ready_i,
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
  output logic [$clog2(DEPTH)-1:0]    idx_o,
  output logic                        found_o
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] oldest;

  // A ready entry survives only if it is older than every other ready one.
  always_comb begin
    oldest = ready_i;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_i[j] && !older_i[i][j]) begin
          oldest[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    idx_o   = '0;
    found_o = |oldest;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (oldest[i]) idx_o = IW'(i);
    end
  end
endmodule

// File: rtl/rs_age_cdb.sv
// Reservation station: CDB operand capture, age-ordered issue to one ALU.
module rs_age_cdb
  import rs_age_cdb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int N_CDB = 2,
  parameter int OP_W  = RS_OP_W,
  parameter int XLEN  = RS_XLEN,
  parameter int TAG_W = RS_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [OP_W-1:0]        in_op,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [TAG_W-1:0]       in_rob_tag,
  input  logic [TAG_W-1:0]       in_rs1_tag,
  input  logic [XLEN-1:0]        in_rs1_value,
  input  logic [TAG_W-1:0]       in_rs2_tag,
  input  logic [XLEN-1:0]        in_rs2_value,
  output logic                   out_full,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*TAG_W-1:0] cdb_tag,
  input  logic [N_CDB*XLEN-1:0]  cdb_value,
  output logic                   out_alu_valid,
  input  logic                   out_alu_ready,
  output logic [OP_W-1:0]        out_alu_op,
  output logic [XLEN-1:0]        out_alu_rs1,
  output logic [XLEN-1:0]        out_alu_rs2,
  output logic [XLEN-1:0]        out_alu_imm,
  output logic [XLEN-1:0]        out_alu_pc,
  output logic [TAG_W-1:0]       out_alu_tag
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] ZT  = TAG_W'(ZERO_TAG);
  localparam logic [OP_W-1:0]  NOP_OP = OP_W'(NOP);

  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [OP_W-1:0]  op_d  [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [XLEN-1:0]  pc_d  [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  imm_d [DEPTH];
  logic [TAG_W-1:0] rt_q  [DEPTH];
  logic [TAG_W-1:0] rt_d  [DEPTH];
  logic [TAG_W-1:0] t1_q  [DEPTH];
  logic [TAG_W-1:0] t1_d  [DEPTH];
  logic [XLEN-1:0]  v1_q  [DEPTH];
  logic [XLEN-1:0]  v1_d  [DEPTH];
  logic [TAG_W-1:0] t2_q  [DEPTH];
  logic [TAG_W-1:0] t2_d  [DEPTH];
  logic [XLEN-1:0]  v2_q  [DEPTH];
  logic [XLEN-1:0]  v2_d  [DEPTH];

  logic             val_q, val_d;
  logic [OP_W-1:0]  aop_q, aop_d;
  logic [XLEN-1:0]  ars1_q, ars1_d;
  logic [XLEN-1:0]  ars2_q, ars2_d;
  logic [XLEN-1:0]  aimm_q, aimm_d;
  logic [XLEN-1:0]  apc_q, apc_d;
  logic [TAG_W-1:0] atag_q, atag_d;

  logic [DEPTH-1:0] ready;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic [IW-1:0]    free_idx;
  logic             issue_go;
  logic             disp_go;
  logic [TAG_W-1:0] n1_t, n2_t;
  logic [XLEN-1:0]  n1_v, n2_v;

  assign out_full = &busy_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && t1_q[i] == ZT && t2_q[i] == ZT;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_sel (
    .ready_i (ready),
    .older_i (age_q),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  assign issue_go = !flush && (!val_q || out_alu_ready) && sel_found;
  assign disp_go  = !flush && in_valid && !out_full;

  // Same-cycle bypass; descending scan lets the lowest port win.
  always_comb begin
    n1_t = in_rs1_tag;
    n1_v = in_rs1_value;
    n2_t = in_rs2_tag;
    n2_v = in_rs2_value;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && in_rs1_tag != ZT &&
          in_rs1_tag == cdb_tag[k*TAG_W +: TAG_W]) begin
        n1_t = ZT;
        n1_v = cdb_value[k*XLEN +: XLEN];
      end
      if (cdb_valid[k] && in_rs2_tag != ZT &&
          in_rs2_tag == cdb_tag[k*TAG_W +: TAG_W]) begin
        n2_t = ZT;
        n2_v = cdb_value[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    age_d  = age_q;
    op_d   = op_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    rt_d   = rt_q;
    t1_d   = t1_q;
    v1_d   = v1_q;
    t2_d   = t2_q;
    v2_d   = v2_q;
    val_d  = val_q;
    aop_d  = aop_q;
    ars1_d = ars1_q;
    ars2_d = ars2_q;
    aimm_d = aimm_q;
    apc_d  = apc_q;
    atag_d = atag_q;

    for (int i = 0; i < DEPTH; i++) begin
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if (busy_q[i] && cdb_valid[k] && t1_q[i] != ZT &&
            t1_q[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
          t1_d[i] = ZT;
          v1_d[i] = cdb_value[k*XLEN +: XLEN];
        end
        if (busy_q[i] && cdb_valid[k] && t2_q[i] != ZT &&
            t2_q[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
          t2_d[i] = ZT;
          v2_d[i] = cdb_value[k*XLEN +: XLEN];
        end
      end
    end

    if (val_q && out_alu_ready) val_d = FALSE;

    if (issue_go) begin
      val_d   = TRUE;
      aop_d   = op_q[sel_idx];
      ars1_d  = v1_q[sel_idx];
      ars2_d  = v2_q[sel_idx];
      aimm_d  = imm_q[sel_idx];
      apc_d   = pc_q[sel_idx];
      atag_d  = rt_q[sel_idx];
      busy_d[sel_idx] = FALSE;
    end

    // New entry is younger than everything currently held.
    if (disp_go) begin
      busy_d[free_idx] = TRUE;
      op_d[free_idx]   = in_op;
      pc_d[free_idx]   = in_pc;
      imm_d[free_idx]  = in_imm;
      rt_d[free_idx]   = in_rob_tag;
      t1_d[free_idx]   = n1_t;
      v1_d[free_idx]   = n1_v;
      t2_d[free_idx]   = n2_t;
      v2_d[free_idx]   = n2_v;
      age_d[free_idx]  = '0;
      for (int j = 0; j < DEPTH; j++) begin
        age_d[j][free_idx] = busy_q[j];
      end
    end

    if (flush) begin
      busy_d = '0;
      age_d  = '0;
      val_d  = FALSE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      age_q  <= '0;
      val_q  <= FALSE;
      aop_q  <= NOP_OP;
      ars1_q <= '0;
      ars2_q <= '0;
      aimm_q <= '0;
      apc_q  <= '0;
      atag_q <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      age_q  <= age_d;
      op_q   <= op_d;
      pc_q   <= pc_d;
      imm_q  <= imm_d;
      rt_q   <= rt_d;
      t1_q   <= t1_d;
      v1_q   <= v1_d;
      t2_q   <= t2_d;
      v2_q   <= v2_d;
      val_q  <= val_d;
      aop_q  <= aop_d;
      ars1_q <= ars1_d;
      ars2_q <= ars2_d;
      aimm_q <= aimm_d;
      apc_q  <= apc_d;
      atag_q <= atag_d;
    end
  end

  assign out_alu_valid = val_q;
  assign out_alu_op    = aop_q;
  assign out_alu_rs1   = ars1_q;
  assign out_alu_rs2   = ars2_q;
  assign out_alu_imm   = aimm_q;
  assign out_alu_pc    = apc_q;
  assign out_alu_tag   = atag_q;
endmodule
